exp_golomb_decoding_ctrl: RTL
=============================

EXP_GOLOMB_DECODING_CTRL -- requirements
Module: exp_golomb_decoding_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset; ports as listed below, clock and reset first.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- exp_golomb_start  in  1  one-cycle request to decode one syntax element
- exp_golomb_mode  in  2  00 ue(v), 01 se(v), 10 te(v) range 1, 11 reserved; sampled with start
- BitStream_buffer_output  in  16  current bitstream window, MSB = next bit
- heading_one_pos  in  4  leading-zero count from the heading_one_detector sibling
- shift_ack  in  1  buffer has consumed the requested bits and the window is updated
- heading_one_en  out  1  detector enable, active-low: 0 = detect
- shift_req  out  1  one-cycle request to consume shift_len bits
- shift_len  out  5  bits to consume, 1..16
- exp_golomb_value  out  16  decoded value, two's complement for se
- exp_golomb_valid  out  1  one-cycle pulse, value valid
- exp_golomb_error  out  1  one-cycle pulse, illegal code or mode
- busy  out  1  high in every state except IDLE

Function
REQ-003 The FSM SHALL use states IDLE, DETECT, WAIT_PREFIX, SUFFIX, WAIT_SUFFIX, DONE and ERROR.
REQ-004 In IDLE, start=1 SHALL latch the mode and move to DETECT; start SHALL be ignored in every other state.
REQ-005 heading_one_en SHALL be 0 only in DETECT and 1 in all other states.
REQ-006 DETECT with mode te SHALL register shift_req=1, shift_len=1, value={15'b0, ~BitStream_buffer_output[15]}, and go to WAIT_SUFFIX.
REQ-007 DETECT with mode 11 SHALL go to ERROR with no shift_req.
REQ-008 DETECT with BitStream_buffer_output==16'h0000 SHALL go to ERROR with no shift_req.
REQ-009 Otherwise DETECT SHALL latch pos=heading_one_pos, register shift_req=1 and shift_len=pos+1, and go to WAIT_PREFIX.
REQ-010 shift_req SHALL be high for exactly one cycle, the first cycle of the WAIT state, with shift_len held stable until ack.
REQ-011 A WAIT state SHALL remain until shift_ack=1; ack in the same cycle as shift_req SHALL be accepted.
REQ-012 In WAIT_PREFIX on ack: pos==0 SHALL set codeNum=0 and go to DONE; pos>0 SHALL go to SUFFIX.
REQ-013 SUFFIX SHALL set codeNum=(2^pos)-1+BitStream_buffer_output[15:16-pos], register shift_req=1 and shift_len=pos, and go to WAIT_SUFFIX.
REQ-014 WAIT_SUFFIX on ack SHALL go to DONE.
REQ-015 codeNum SHALL be 16-bit unsigned; its maximum, pos=15 with suffix all ones, is 65534 with no overflow.
REQ-016 In DONE, ue SHALL output value=codeNum; se SHALL output value=(codeNum+1)>>1 for odd codeNum and -(codeNum>>1) for even codeNum.
REQ-017 DONE SHALL pulse valid for 1 cycle, and value SHALL hold until the next DONE or reset.
REQ-018 DONE SHALL return to IDLE.
REQ-019 ERROR SHALL pulse exp_golomb_error for 1 cycle, leave value unchanged, and return to IDLE.
REQ-020 Latency from start to valid SHALL be 4 cycles plus ack waits for pos==0 and 6 cycles plus ack waits for pos>0, assuming same-cycle ack.

Reset
REQ-021 While reset=1 at a clock edge, the state SHALL go to IDLE.
REQ-022 While reset=1 at a clock edge, outputs SHALL be: value=0, valid=0, error=0, shift_req=0, shift_len=0, busy=0, heading_one_en=1.
REQ-023 Reset in any state, including a WAIT state with an outstanding request, SHALL abort the decode with no further shift_req.
REQ-024 A shift_ack arriving after reset SHALL be ignored.

Structure
REQ-025 The mode encodings, state encoding and the constant MAX_PREFIX=15 SHALL live in the shared package h264_exp_golomb_pkg.
REQ-026 The mapping from codeNum and mode to value SHALL be one combinational sub-module, exp_golomb_value_map.
REQ-027 heading_one_detector SHALL remain an external sibling and SHALL NOT be instantiated inside this block.

Verification
REQ-028 ue, window 16'h8000, pos 0, immediate ack -> shift_len=1, value=0, valid 4 cycles after start.
REQ-029 ue, window 16'b0010_1xxx (pos 2), after prefix ack window 16'b01xx -> shift_len 3 then 2, value=4.
REQ-030 se, codeNum 4 -> value=16'hFFFE (-2); se, codeNum 3 -> value=2; te, bit 0 -> value=1, shift_len=1.
REQ-031 ue, window 16'h0001 (pos 15), suffix window 16'hFFFE -> shift_len 16 then 15, value=65534.
REQ-032 Window 16'h0000, or mode 11 -> error pulse, no shift_req, busy low next cycle.
REQ-033 Reset asserted in WAIT_SUFFIX with ack withheld -> IDLE next cycle, outputs at reset values; start during busy -> ignored.

Source files
------------

// File: rtl/h264_exp_golomb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : h264_exp_golomb_pkg
// Brief    : Shared encodings and constants for the Exp-Golomb decode control.
// Revision : 1.0
// ============================================================================
package h264_exp_golomb_pkg;

    localparam int MAX_PREFIX = 15;
    localparam int POS_W      = $clog2(MAX_PREFIX + 1);
    localparam int WIN_W      = 16;
    localparam int LEN_W      = 5;

    typedef enum logic [1:0] {
        MODE_UE   = 2'b00,
        MODE_SE   = 2'b01,
        MODE_TE   = 2'b10,
        MODE_RSVD = 2'b11
    } eg_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DETECT      = 3'd1,
        ST_WAIT_PREFIX = 3'd2,
        ST_SUFFIX      = 3'd3,
        ST_WAIT_SUFFIX = 3'd4,
        ST_DONE        = 3'd5,
        ST_ERROR       = 3'd6
    } eg_state_t;

    // 2^pos - 1; pos <= MAX_PREFIX keeps this inside 16 bits.
    function automatic logic [WIN_W-1:0] prefix_base(input logic [POS_W-1:0] pos);
        return WIN_W'((17'd1 << pos) - 17'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exp_golomb_value_map.sv
`default_nettype none
// ============================================================================
// Module   : exp_golomb_value_map
// Brief    : Maps an unsigned codeNum to the ue/se/te output value.
// Revision : 1.0
// ============================================================================
module exp_golomb_value_map
    import h264_exp_golomb_pkg::*;
(
    input  logic [WIN_W-1:0] i_code_num,
    input  eg_mode_t         i_mode,
    output logic [WIN_W-1:0] o_value
);

    logic [WIN_W-1:0] w_half;

    always_comb begin
        w_half  = {1'b0, i_code_num[WIN_W-1:1]};
        o_value = i_code_num;
        if (i_mode == MODE_SE) begin
            // odd -> (k+1)/2 == (k>>1)+1 ; even -> -(k>>1)
            if (i_code_num[0]) begin
                o_value = w_half + 16'd1;
            end else begin
                o_value = (~w_half) + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exp_golomb_decoding_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exp_golomb_decoding_ctrl
// Brief    : Sequences prefix/suffix shifts of one Exp-Golomb syntax element.
// Revision : 1.0
// ============================================================================
module exp_golomb_decoding_ctrl
    import h264_exp_golomb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_golomb_start,
    input  logic [1:0]        exp_golomb_mode,
    input  logic [WIN_W-1:0]  BitStream_buffer_output,
    input  logic [POS_W-1:0]  heading_one_pos,
    input  logic              shift_ack,
    output logic              heading_one_en,
    output logic              shift_req,
    output logic [LEN_W-1:0]  shift_len,
    output logic [WIN_W-1:0]  exp_golomb_value,
    output logic              exp_golomb_valid,
    output logic              exp_golomb_error,
    output logic              busy
);

    eg_state_t          state_q,     state_d;
    eg_mode_t           mode_q,      mode_d;
    logic [POS_W-1:0]   pos_q,       pos_d;
    logic [WIN_W-1:0]   code_num_q,  code_num_d;
    logic [WIN_W-1:0]   value_q,     value_d;
    logic               valid_q,     valid_d;
    logic               error_q,     error_d;
    logic               shift_req_q, shift_req_d;
    logic [LEN_W-1:0]   shift_len_q, shift_len_d;

    logic [WIN_W-1:0]   w_suffix;
    logic [WIN_W-1:0]   w_mapped;

    exp_golomb_value_map u_value_map (
        .i_code_num (code_num_q),
        .i_mode     (mode_q),
        .o_value    (w_mapped)
    );

    // Window is already advanced past the prefix, so the suffix is its top pos bits.
    assign w_suffix = BitStream_buffer_output >> (5'd16 - {1'b0, pos_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_UE;
            pos_q       <= '0;
            code_num_q  <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            shift_req_q <= 1'b0;
            shift_len_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pos_q       <= pos_d;
            code_num_q  <= code_num_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            shift_req_q <= shift_req_d;
            shift_len_q <= shift_len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pos_d       = pos_q;
        code_num_d  = code_num_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        shift_req_d = 1'b0;
        shift_len_d = shift_len_q;

        case (state_q)
            ST_IDLE: begin
                if (exp_golomb_start) begin
                    mode_d  = eg_mode_t'(exp_golomb_mode);
                    state_d = ST_DETECT;
                end
            end
            ST_DETECT: begin
                if (mode_q == MODE_RSVD) begin
                    state_d = ST_ERROR;
                end else if (mode_q == MODE_TE) begin
                    shift_req_d = 1'b1;
                    shift_len_d = 5'd1;
                    code_num_d  = {15'b0, ~BitStream_buffer_output[WIN_W-1]};
                    state_d     = ST_WAIT_SUFFIX;
                end else if (BitStream_buffer_output == '0) begin
                    state_d = ST_ERROR;
                end else begin
                    pos_d       = heading_one_pos;
                    shift_req_d = 1'b1;
                    shift_len_d = {1'b0, heading_one_pos} + 5'd1;
                    state_d     = ST_WAIT_PREFIX;
                end
            end
            ST_WAIT_PREFIX: begin
                if (shift_ack) begin
                    if (pos_q == '0) begin
                        code_num_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        state_d    = ST_SUFFIX;
                    end
                end
            end
            ST_SUFFIX: begin
                code_num_d  = prefix_base(pos_q) + w_suffix;
                shift_req_d = 1'b1;
                shift_len_d = {1'b0, pos_q};
                state_d     = ST_WAIT_SUFFIX;
            end
            ST_WAIT_SUFFIX: begin
                if (shift_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                value_d = w_mapped;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign heading_one_en   = (state_q != ST_DETECT);
    assign busy             = (state_q != ST_IDLE);
    assign shift_req        = shift_req_q;
    assign shift_len        = shift_len_q;
    assign exp_golomb_value = value_q;
    assign exp_golomb_valid = valid_q;
    assign exp_golomb_error = error_q;

endmodule
`default_nettype wire
